// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: request side (instruction + format + tag)
// and response side (extended immediate + tag + error flag), plus a debug view
// of the buffer state.
//
// valid/ready: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid and its payload steady until the
// transfer. valid never depends on ready. in_ready comes from registered
// state only.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      inst;
   logic [2:0]       type_imm;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  imm;
   logic [TAG_W-1:0] out_tag;
   logic             imm_err;
   logic [1:0]       state;

   // Environment side: drives requests and consumes responses.
   modport master (
      output in_valid, inst, type_imm, in_tag, out_ready,
      input  in_ready, out_valid, imm, out_tag, imm_err, state
   );

   // Block side.
   modport slave (
      input  in_valid, inst, type_imm, in_tag, out_ready,
      output in_ready, out_valid, imm, out_tag, imm_err, state
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a two-entry elastic buffer.
// The immediate is extended at the input and stored already extended.
// M (main) drives the outputs. K (skid) absorbs one entry while the consumer
// stalls. The buffer state is exactly {M.v, K.v}.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   imm_gen_stage_if.slave   bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             m_v;
   logic             k_v;
   logic             in_fire;
   logic             out_fire;
   logic             ld_m_in;
   logic             ld_m_k;
   logic             ld_k;

   logic [31:0]      imm32;
   logic [XLEN-1:0]  ext_imm;
   logic             ext_err;

   logic [XLEN-1:0]  m_imm;
   logic [TAG_W-1:0] m_tag;
   logic             m_err;
   logic [XLEN-1:0]  k_imm;
   logic [TAG_W-1:0] k_tag;
   logic             k_err;

   // The opcode field carries no immediate bits.
   logic             unused_opcode;
   assign unused_opcode = ^bus.inst[6:0];

   assign m_v      = state_q[1];
   assign k_v      = state_q[0];
   assign in_fire  = bus.in_valid & ~k_v;
   assign out_fire = m_v & bus.out_ready;

   assign bus.in_ready  = ~k_v;
   assign bus.out_valid = m_v;
   assign bus.imm       = m_imm;
   assign bus.out_tag   = m_tag;
   assign bus.imm_err   = m_err;
   assign bus.state     = state_q;

   // Decode the format into a 32-bit sign-correct value, then widen to XLEN
   // by replicating bit 31. Zero-extended formats never set bit 31.
   always_comb begin
      imm32   = 32'd0;
      ext_err = 1'b0;
      case (bus.type_imm)
         3'd0: imm32 = {bus.inst[31:12], 12'd0};
         3'd1: imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
         3'd2: imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                        bus.inst[30:25], bus.inst[11:8], 1'b0};
         3'd3: imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                        bus.inst[20], bus.inst[30:21], 1'b0};
         3'd4: imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
         3'd5: imm32 = {27'd0, bus.inst[19:15]};
         3'd6: begin
            if (XLEN == 64) imm32 = {26'd0, bus.inst[25:20]};
            else            imm32 = {27'd0, bus.inst[24:20]};
         end
         default: ext_err = 1'b1;
      endcase
      ext_imm = XLEN'({{32{imm32[31]}}, imm32});
   end

   // Buffer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next state and register load selects; flush overrides every transfer.
   always_comb begin
      state_d = state_q;
      ld_m_in = 1'b0;
      ld_m_k  = 1'b0;
      ld_k    = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  ld_m_in = 1'b1;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  ld_m_in = 1'b1;
               end else if (in_fire) begin
                  ld_k    = 1'b1;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  ld_m_k  = 1'b1;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Payload registers; they keep stale contents on flush since the valid
   // bits live in the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_imm <= '0;
         m_tag <= '0;
         m_err <= 1'b0;
         k_imm <= '0;
         k_tag <= '0;
         k_err <= 1'b0;
      end else begin
         if (ld_m_in) begin
            m_imm <= ext_imm;
            m_tag <= bus.in_tag;
            m_err <= ext_err;
         end else if (ld_m_k) begin
            m_imm <= k_imm;
            m_tag <= k_tag;
            m_err <= k_err;
         end
         if (ld_k) begin
            k_imm <= ext_imm;
            k_tag <= bus.in_tag;
            k_err <= ext_err;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=32 and an XLEN=64 instance share one
// stimulus stream. A queue of expected entries models the two-entry buffer,
// and immediates are computed arithmetically from the field weights.
module tb_imm_gen_stage;

   localparam int     TAG_W    = 8;
   localparam logic [7:0] DROP_TAG = 8'hEE;
   localparam longint P12 = 64'sd4096;
   localparam longint P13 = 64'sd8192;
   localparam longint P21 = 64'sd2097152;
   localparam longint P32 = 64'sd4294967296;

   typedef struct {
      logic [63:0] e64;
      logic [31:0] e32;
      logic [7:0]  tag;
      logic        err;
   } rec_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] inst;
   logic [2:0]  type_imm;
   logic [7:0]  in_tag;
   logic        out_ready;

   int   tests;
   int   fails;
   bit   seen_drop;
   bit   ov_en;
   logic [31:0] ov32;
   logic [63:0] ov64;
   rec_t exp_q[$];

   imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

   assign bus32.in_valid  = in_valid;
   assign bus32.inst      = inst;
   assign bus32.type_imm  = type_imm;
   assign bus32.in_tag    = in_tag;
   assign bus32.out_ready = out_ready;
   assign bus64.in_valid  = in_valid;
   assign bus64.inst      = inst;
   assign bus64.type_imm  = type_imm;
   assign bus64.in_tag    = in_tag;
   assign bus64.out_ready = out_ready;

   imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave)
   );
   imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      tests++;
      fails++;
      $error("FAIL %s: observed timeout expected completion", tag);
   endtask

   function automatic longint field(input logic [31:0] w, input int hi, input int lo);
      logic [31:0] mask;
      mask = (32'd1 << (hi - lo + 1)) - 32'd1;
      return longint'((w >> lo) & mask);
   endfunction

   // Immediate value as a signed number from the field weights, returned as
   // two's complement in 64 bits.
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input int t, input int xlen);
      longint v;
      v = 0;
      case (t)
         0: begin v = field(w, 31, 12) * P12; if (w[31]) v -= P32; end
         1: begin v = field(w, 31, 20); if (w[31]) v -= P12; end
         2: begin
            v = field(w, 7, 7) * 2048 + field(w, 30, 25) * 32 + field(w, 11, 8) * 2;
            if (w[31]) v -= P12;
         end
         3: begin
            v = field(w, 19, 12) * P12 + field(w, 20, 20) * 2048 + field(w, 30, 21) * 2;
            if (w[31]) v -= (P21 / 2);
         end
         4: begin v = field(w, 31, 25) * 32 + field(w, 11, 7); if (w[31]) v -= P12; end
         5: v = field(w, 19, 15);
         6: v = (xlen == 64) ? field(w, 25, 20) : field(w, 24, 20);
         default: v = 0;
      endcase
      if (v >= P13 * P13 * P13 * P13) v = 0;
      return 64'(v);
   endfunction

   function automatic rec_t make_rec();
      rec_t r;
      logic [63:0] t32;
      t32   = ref_imm(inst, int'(type_imm), 32);
      r.e64 = ref_imm(inst, int'(type_imm), 64);
      r.e32 = t32[31:0];
      r.tag = in_tag;
      r.err = (type_imm == 3'd7);
      if (ov_en) begin
         r.e32 = ov32;
         r.e64 = ov64;
      end
      return r;
   endfunction

   // One clock cycle: check outputs against the model at the negedge, account
   // for the transfers of the coming edge, then step past the posedge.
   task automatic tick(output bit fired, output bit popped);
      rec_t r;
      bit   exp_vld;
      bit   exp_rdy;
      @(negedge clk);
      exp_vld = (exp_q.size() > 0);
      exp_rdy = (exp_q.size() < 2);
      chk("out_valid", {63'd0, bus32.out_valid}, {63'd0, exp_vld});
      chk("out_valid64", {63'd0, bus64.out_valid}, {63'd0, exp_vld});
      chk("in_ready", {63'd0, bus32.in_ready}, {63'd0, exp_rdy});
      chk("in_ready64", {63'd0, bus64.in_ready}, {63'd0, exp_rdy});
      if (bus32.out_valid && bus32.out_tag == DROP_TAG) seen_drop = 1'b1;
      popped = exp_vld && out_ready;
      if (popped) begin
         r = exp_q.pop_front();
         chk("imm32", {32'd0, bus32.imm}, {32'd0, r.e32});
         chk("imm64", bus64.imm, r.e64);
         chk("out_tag", {56'd0, bus32.out_tag}, {56'd0, r.tag});
         chk("out_tag64", {56'd0, bus64.out_tag}, {56'd0, r.tag});
         chk("imm_err", {63'd0, bus32.imm_err}, {63'd0, r.err});
         chk("imm_err64", {63'd0, bus64.imm_err}, {63'd0, r.err});
      end
      fired = in_valid && exp_rdy && !flush;
      if (flush) exp_q.delete();
      else if (fired) exp_q.push_back(make_rec());
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic send(input logic [31:0] w, input logic [2:0] t, input logic [7:0] tag,
                       input bit use_ov, input logic [31:0] e32, input logic [63:0] e64);
      bit f;
      bit p;
      bit done;
      in_valid = 1'b1;
      inst     = w;
      type_imm = t;
      in_tag   = tag;
      ov_en    = use_ov;
      ov32     = e32;
      ov64     = e64;
      done     = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         tick(f, p);
         done = f;
      end
      if (!done) timeout_fail("send");
      in_valid = 1'b0;
      ov_en    = 1'b0;
   endtask

   task automatic drain();
      bit f;
      bit p;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(f, p);
      if (exp_q.size() > 0) timeout_fail("drain");
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_out_valid"}, {63'd0, bus32.out_valid}, 64'd0);
      chk({tag, "_in_ready"}, {63'd0, bus32.in_ready}, 64'd1);
      chk({tag, "_imm"}, {32'd0, bus32.imm}, 64'd0);
      chk({tag, "_imm64"}, bus64.imm, 64'd0);
      chk({tag, "_tag"}, {56'd0, bus32.out_tag}, 64'd0);
      chk({tag, "_err"}, {63'd0, bus32.imm_err}, 64'd0);
      chk({tag, "_out_valid64"}, {63'd0, bus64.out_valid}, 64'd0);
   endtask

   initial begin
      bit f;
      bit p;
      int acc;
      int outs;
      logic [7:0] cur;
      tests = 0; fails = 0; seen_drop = 1'b0;
      ov_en = 1'b0; ov32 = '0; ov64 = '0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      inst = '0; type_imm = '0; in_tag = '0; out_ready = 1'b0;

      // reset state
      #2;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // format sweep with literal expectations
      out_ready = 1'b1;
      send(32'hFFF0_0093, 3'd1, 8'h01, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      send(32'h8000_0063, 3'd2, 8'h02, 1'b1, 32'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000);
      send(32'h0010_00EF, 3'd3, 8'h03, 1'b1, 32'h0000_0800, 64'h0000_0000_0000_0800);
      send(32'h8000_0037, 3'd0, 8'h04, 1'b1, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
      send(32'h03F0_1013, 3'd6, 8'h05, 1'b1, 32'h0000_001F, 64'h0000_0000_0000_003F);
      send(32'h0000_7FFF, 3'd7, 8'h06, 1'b1, 32'h0, 64'h0);
      // every format with random words, model expectations
      for (int i = 0; i < 24; i++)
         send($urandom, 3'(i % 8), 8'($urandom_range(0, 223)), 1'b0, 32'h0, 64'h0);
      drain();

      // back-pressure: tags 1..4, consumer stalled for 3 cycles
      out_ready = 1'b0;
      cur = 8'd1;
      acc = 0;
      for (int cyc = 0; cyc < 30 && (cur <= 8'd4 || exp_q.size() > 0); cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (cur <= 8'd4);
         inst      = $urandom;
         type_imm  = 3'($urandom_range(0, 6));
         in_tag    = cur;
         if (cyc == 2) chk("bp_in_ready_low", {63'd0, bus32.in_ready}, 64'd0);
         tick(f, p);
         if (f) begin
            cur++;
            acc++;
         end
      end
      chk("bp_accepted", 64'(acc), 64'd4);
      drain();

      // simultaneous accept and deliver in ONE
      send(32'h1234_5678, 3'd4, 8'h10, 1'b0, 32'h0, 64'h0);
      outs = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         inst     = $urandom;
         type_imm = 3'($urandom_range(0, 7));
         in_tag   = 8'h11 + 8'(i);
         tick(f, p);
         if (p) outs++;
      end
      chk("ss_outputs", 64'(outs), 64'd10);
      drain();

      // flush while FULL with a new entry offered
      out_ready = 1'b0;
      send(32'hABCD_0123, 3'd1, 8'h20, 1'b0, 32'h0, 64'h0);
      send(32'h5555_AAAA, 3'd5, 8'h21, 1'b0, 32'h0, 64'h0);
      in_valid = 1'b1;
      in_tag   = DROP_TAG;
      flush    = 1'b1;
      tick(f, p);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {63'd0, bus32.out_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, bus32.in_ready}, 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick(f, p);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         inst      = $urandom;
         type_imm  = 3'($urandom_range(0, 7));
         in_tag    = 8'($urandom_range(0, 223));
         tick(f, p);
      end
      drain();

      // asynchronous reset while the buffer holds entries
      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 3'd0, 8'h30, 1'b0, 32'h0, 64'h0);
      send(32'h8765_4321, 3'd2, 8'h31, 1'b0, 32'h0, 64'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         in_valid  = ($urandom_range(0, 1) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         inst      = $urandom;
         type_imm  = 3'($urandom_range(0, 7));
         in_tag    = 8'($urandom_range(0, 223));
         tick(f, p);
      end
      drain();
      tick(f, p);

      chk("dropped_tag_seen", {63'd0, seen_drop}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
